// File: rtl/csa_batch_sched.sv
// csa_batch_sched: sequences an 8-input carry-save compressor over a stream of
// six-word beats, folding the registered (C,S) pair back in on every beat, and
// resolves the final redundant pair into a binary sum once the batch ends.
module csa_batch_sched #(
  parameter int WORD_W          = 20,
  parameter int BEATS_PER_BATCH = 6,
  parameter int CNT_W           = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [BEATS_PER_BATCH-1:0][WORD_W-1:0]    in_words,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WORD_W-1:0]                         out_c,
  output logic [WORD_W-1:0]                         out_s,
  output logic [WORD_W-1:0]                         out_sum,
  output logic [CNT_W-1:0]                          out_beats,
  output logic                                      busy
);

  // The compressor geometry is fixed; refuse to elaborate any other shape.
  if (WORD_W != 20) begin : g_bad_width
    $error("csa_batch_sched: WORD_W must be 20");
  end
  if (BEATS_PER_BATCH != 6) begin : g_bad_beats
    $error("csa_batch_sched: BEATS_PER_BATCH must be 6");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef logic [WORD_W-1:0] word_t;

  state_t            state;
  word_t             acc_c, acc_s;
  logic [CNT_W-1:0]  count;
  word_t             fb_c, fb_s;
  word_t             cmp_c, cmp_s;
  logic              accept;

  // 3:2 carry-save cell; carry is returned already weight-aligned (shifted left).
  function automatic void csa3(input word_t x, input word_t y, input word_t z,
                               output word_t s, output word_t c);
    word_t maj;
    s   = x ^ y ^ z;
    maj = (x & y) | (x & z) | (y & z);
    c   = {maj[WORD_W-2:0], 1'b0};
  endfunction

  // Eight-to-two compressor tree; feedback is forced to zero in IDLE so a new
  // batch never picks up the previous batch's accumulator.
  always_comb begin
    word_t s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
    fb_c = (state == IDLE) ? '0 : acc_c;
    fb_s = (state == IDLE) ? '0 : acc_s;
    csa3(in_words[0], in_words[1], in_words[2], s1, c1);
    csa3(in_words[3], in_words[4], in_words[5], s2, c2);
    csa3(fb_s, fb_c, s1, s3, c3);
    csa3(c1, s2, c2, s4, c4);
    csa3(s3, c3, s4, s5, c5);
    csa3(c4, s5, c5, cmp_s, cmp_c);
  end

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Batch sequencer: accumulate beats, resolve once, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_c     <= '0;
      acc_s     <= '0;
      count     <= '0;
      out_c     <= '0;
      out_s     <= '0;
      out_sum   <= '0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_c <= cmp_c;
            acc_s <= cmp_s;
            count <= CNT_W'(1);
            state <= in_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_c <= cmp_c;
            acc_s <= cmp_s;
            if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= acc_c + acc_s;
          out_c     <= acc_c;
          out_s     <= acc_s;
          out_beats <= count;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_c     <= '0;
            acc_s     <= '0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_batch_sched.sv
// Directed self-checking bench for csa_batch_sched.
module tb_csa_batch_sched;

  localparam int W = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0][W-1:0] in_words = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_c, out_s, out_sum;
  logic [7:0]        out_beats;
  logic              busy;

  int checks = 0;
  int errors = 0;

  csa_batch_sched dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_words(in_words), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_c(out_c), .out_s(out_s), .out_sum(out_sum),
    .out_beats(out_beats), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0][W-1:0] mk(input logic [W-1:0] a0, a1, a2, a3, a4, a5);
    logic [5:0][W-1:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5;
    return r;
  endfunction

  // Present one beat at a negedge; it is taken on the next posedge if in_ready.
  task automatic beat(input logic [5:0][W-1:0] w, input logic last);
    in_words = w; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called at the negedge after the last beat was accepted; checks latency and result.
  task automatic finish_batch(input string name, input logic [W-1:0] exp_sum, input logic [7:0] exp_beats);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s resolve_cycle: out_valid=%0b in_ready=%0b required 0 0", name, out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid: got %0b required 1", name, out_valid);
    end
    checks++;
    if (out_sum !== exp_sum) begin
      errors++;
      $display("FAIL %s out_sum: got %h required %h", name, out_sum, exp_sum);
    end
    checks++;
    if (W'(out_c + out_s) !== exp_sum) begin
      errors++;
      $display("FAIL %s c_plus_s: got %h required %h", name, W'(out_c + out_s), exp_sum);
    end
    checks++;
    if (out_beats !== exp_beats) begin
      errors++;
      $display("FAIL %s out_beats: got %0d required %0d", name, out_beats, exp_beats);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: out_valid=%0b busy=%0b in_ready=%0b required 0 0 1",
               name, out_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_sum !== '0 ||
        out_c !== '0 || out_s !== '0 || out_beats !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%0b ir=%0b busy=%0b sum=%h c=%h s=%h beats=%0d required 0 1 0 0 0 0 0",
               out_valid, in_ready, busy, out_sum, out_c, out_s, out_beats);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    beat(mk(1, 2, 3, 4, 5, 6), 1'b1);
    finish_batch("single", 20'd21, 8'd1);
  endtask

  task automatic test_all_ones();
    beat(mk('1, '1, '1, '1, '1, '1), 1'b0);
    beat(mk('1, '1, '1, '1, '1, '1), 1'b1);
    finish_batch("all_ones", 20'hFFFF4, 8'd2);
  endtask

  task automatic test_random_gaps();
    logic [W-1:0] model = '0;
    logic [5:0][W-1:0] w;
    int acc = 0;
    int cyc = 0;
    while (acc < 10 && cyc < 200) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random in_ready: got %0b required 1 (cycle %0d)", in_ready, cyc);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 6; k++) begin
          w[k] = W'($urandom);
          model = model + w[k];
        end
        in_words = w; in_last = (acc == 9); in_valid = 1'b1;
        acc++;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (acc != 10) begin
      errors++;
      $display("FAIL random timeout: beats sent %0d required 10", acc);
    end
    finish_batch("random", model, 8'd10);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] held_sum;
    beat(mk(100, 200, 300, 0, 0, 1), 1'b1);
    @(negedge clk);
    held_sum = out_sum;
    checks++;
    if (out_valid !== 1'b1 || held_sum !== 20'd601) begin
      errors++;
      $display("FAIL stall first_result: ov=%0b sum=%0d required 1 601", out_valid, held_sum);
    end
    in_words = mk(55, 55, 55, 55, 55, 55); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== held_sum || out_beats !== 8'd1) begin
        errors++;
        $display("FAIL stall hold%0d: ov=%0b ir=%0b sum=%0d beats=%0d required 1 0 601 1",
                 i, out_valid, in_ready, out_sum, out_beats);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== held_sum) begin
      errors++;
      $display("FAIL stall release: ov=%0b busy=%0b sum=%0d required 0 0 601", out_valid, busy, out_sum);
    end
    beat(mk(7, 0, 0, 0, 0, 0), 1'b1);
    finish_batch("no_stale", 20'd7, 8'd1);
  endtask

  task automatic test_reset_mid_batch();
    beat(mk(1, 1, 1, 1, 1, 1), 1'b0);
    beat(mk(2, 2, 2, 2, 2, 2), 1'b0);
    beat(mk(3, 3, 3, 3, 3, 3), 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset busy_before: got %0b required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_beats !== '0) begin
      errors++;
      $display("FAIL midreset state: busy=%0b ir=%0b ov=%0b sum=%h beats=%0d required 0 1 0 0 0",
               busy, in_ready, out_valid, out_sum, out_beats);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(mk(0, 0, 0, 0, 0, 9), 1'b1);
    finish_batch("after_reset", 20'd9, 8'd1);
  endtask

  task automatic test_saturation();
    logic [W-1:0] model = '0;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a;
      a = W'(i * 3001);
      model = model + a + 20'hABCDE;
      beat(mk(a, 0, 0, 0, 0, 20'hABCDE), (i == 299));
    end
    finish_batch("saturate", model, 8'd255);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_all_ones();
    test_random_gaps();
    test_back_to_back();
    test_reset_mid_batch();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
